// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared processor types for pipeline stall/flush control.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    localparam int c_reg_addr_w = 5;

    typedef enum logic [0:0] {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    // Field order defines the packed bundle layout, MSB first.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
    } ctrl_t;

    localparam int c_ctrl_w = $bits(ctrl_t);

endpackage
`default_nettype wire

// File: rtl/hazard_cmp.sv
`default_nettype none
// ============================================================================
// Module  : hazard_cmp
// Brief   : Load-use match for one ID source operand against the EX load.
// Revision: 1.0 - initial release
// ============================================================================
module hazard_cmp
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = c_reg_addr_w
)(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  use_rs,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_load,
    output logic                  hit
);

    // x0 is hard-wired zero, so a load targeting it never forwards anything.
    assign hit = ex_load & use_rs & (ex_rd != '0) & (rs == ex_rd);

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Stall/flush/freeze controller for a 5-stage pipeline with counters.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W      = c_reg_addr_w,
    parameter int CNT_W           = 32,
    parameter int LU_STALL_CYCLES = 1
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  cnt_clr,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  idex_en,
    output logic                  exmem_en,
    output logic                  memwb_en,
    output logic                  ifid_flush,
    output logic                  idex_flush,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_events
);

    localparam logic [1:0] c_bub_load = 2'(LU_STALL_CYCLES - 1);

    state_t                r_state;
    logic [1:0]            r_bub;
    logic [CNT_W-1:0]      r_stall;
    logic [CNT_W-1:0]      r_flush;
    logic                  w_freeze;
    logic                  w_hit_rs1;
    logic                  w_hit_rs2;
    logic                  w_hazard;
    ctrl_t                 w_ctrl;
    logic [c_ctrl_w-1:0]   w_bus;

    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs1 (
        .rs      (id_rs1),
        .use_rs  (id_use_rs1),
        .ex_rd   (ex_rd),
        .ex_load (ex_mem_read),
        .hit     (w_hit_rs1)
    );

    hazard_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs2 (
        .rs      (id_rs2),
        .use_rs  (id_use_rs2),
        .ex_rd   (ex_rd),
        .ex_load (ex_mem_read),
        .hit     (w_hit_rs2)
    );

    assign w_freeze = mem_req & ~mem_ready;
    assign w_hazard = w_hit_rs1 | w_hit_rs2;

    // Reset and memory freeze both park every stage; a taken branch beats load-use.
    always_comb begin
        w_ctrl = '0;
        if (rst && !w_freeze) begin
            w_ctrl.pc_en    = 1'b1;
            w_ctrl.ifid_en  = 1'b1;
            w_ctrl.idex_en  = 1'b1;
            w_ctrl.exmem_en = 1'b1;
            w_ctrl.memwb_en = 1'b1;
            if (ex_branch_taken) begin
                w_ctrl.ifid_flush = 1'b1;
                w_ctrl.idex_flush = 1'b1;
            end else if (r_state == ST_LU_STALL || w_hazard) begin
                w_ctrl.pc_en      = 1'b0;
                w_ctrl.ifid_en    = 1'b0;
                w_ctrl.idex_flush = 1'b1;
            end
        end
    end

    assign w_bus = w_ctrl;
    assign {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush} = w_bus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_bub   <= 2'd0;
        end else if (!w_freeze) begin
            if (ex_branch_taken) begin
                r_state <= ST_RUN;
                r_bub   <= 2'd0;
            end else begin
                case (r_state)
                    ST_RUN: begin
                        if (w_hazard) begin
                            r_bub   <= c_bub_load;
                            r_state <= (LU_STALL_CYCLES > 1) ? ST_LU_STALL : ST_RUN;
                        end
                    end
                    ST_LU_STALL: begin
                        // Counter holds bubbles still owed; leave once the last one is issued.
                        if (r_bub <= 2'd1) begin
                            r_bub   <= 2'd0;
                            r_state <= ST_RUN;
                        end else begin
                            r_bub <= r_bub - 2'd1;
                        end
                    end
                    default: begin
                        r_state <= ST_RUN;
                        r_bub   <= 2'd0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall <= '0;
            r_flush <= '0;
        end else if (cnt_clr) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if (!w_ctrl.pc_en && r_stall != '1) begin
                r_stall <= r_stall + CNT_W'(1);
            end
            if (ex_branch_taken && !w_freeze && r_flush != '1) begin
                r_flush <= r_flush + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = r_stall;
    assign flush_events = r_flush;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Checks three pipeline_ctrl configurations against a bubble-count model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_read = 0;
    logic       ex_branch_taken = 0, mem_req = 0, mem_ready = 0, cnt_clr = 0;

    wire [6:0]  ob0, ob1, ob2;
    wire [31:0] sc0, sc1, fe0, fe1;
    wire [3:0]  sc2, fe2;

    int total = 0;
    int bad   = 0;

    // Model: per configuration, the number of extra bubbles still owed.
    int              bub [3] = '{0, 0, 0};
    longint unsigned msc [3] = '{0, 0, 0};
    longint unsigned mfe [3] = '{0, 0, 0};
    int              lu  [3] = '{1, 3, 1};
    int              cw  [3] = '{32, 32, 4};

    always #5 clk = ~clk;

    pipeline_ctrl u_dut0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_en(ob0[6]), .ifid_en(ob0[5]), .idex_en(ob0[4]), .exmem_en(ob0[3]),
        .memwb_en(ob0[2]), .ifid_flush(ob0[1]), .idex_flush(ob0[0]),
        .stall_cycles(sc0), .flush_events(fe0)
    );

    pipeline_ctrl #(.LU_STALL_CYCLES(3)) u_dut1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_en(ob1[6]), .ifid_en(ob1[5]), .idex_en(ob1[4]), .exmem_en(ob1[3]),
        .memwb_en(ob1[2]), .ifid_flush(ob1[1]), .idex_flush(ob1[0]),
        .stall_cycles(sc1), .flush_events(fe1)
    );

    pipeline_ctrl #(.CNT_W(4)) u_dut2 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .pc_en(ob2[6]), .ifid_en(ob2[5]), .idex_en(ob2[4]), .exmem_en(ob2[3]),
        .memwb_en(ob2[2]), .ifid_flush(ob2[1]), .idex_flush(ob2[0]),
        .stall_cycles(sc2), .flush_events(fe2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] out_of(input int m);
        case (m)
            0:       return {57'd0, ob0};
            1:       return {57'd0, ob1};
            default: return {57'd0, ob2};
        endcase
    endfunction

    function automatic logic [63:0] sc_of(input int m);
        case (m)
            0:       return {32'd0, sc0};
            1:       return {32'd0, sc1};
            default: return {60'd0, sc2};
        endcase
    endfunction

    function automatic logic [63:0] fe_of(input int m);
        case (m)
            0:       return {32'd0, fe0};
            1:       return {32'd0, fe1};
            default: return {60'd0, fe2};
        endcase
    endfunction

    // One clock: check outputs mid-cycle, advance the model, check counters after the edge.
    task automatic cycle();
        logic            frz, hz;
        logic [6:0]      exp [3];
        longint unsigned mx;
        @(negedge clk);
        frz = mem_req && !mem_ready;
        hz  = ex_mem_read && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
        for (int m = 0; m < 3; m++) begin
            if (!rst || frz)                exp[m] = 7'b00000_00;
            else if (ex_branch_taken)       exp[m] = 7'b11111_11;
            else if (bub[m] > 0 || hz)      exp[m] = 7'b00111_01;
            else                            exp[m] = 7'b11111_00;
            chk($sformatf("ctrl%0d", m), out_of(m), {57'd0, exp[m]});
        end
        for (int m = 0; m < 3; m++) begin
            mx = (64'd1 << cw[m]) - 64'd1;
            if (!rst) begin
                bub[m] = 0; msc[m] = 0; mfe[m] = 0;
            end else begin
                if (cnt_clr) begin
                    msc[m] = 0; mfe[m] = 0;
                end else begin
                    if (!exp[m][6] && msc[m] < mx) msc[m]++;
                    if (ex_branch_taken && !frz && mfe[m] < mx) mfe[m]++;
                end
                if (!frz) begin
                    if (ex_branch_taken)  bub[m] = 0;
                    else if (bub[m] > 0)  bub[m]--;
                    else if (hz)          bub[m] = lu[m] - 1;
                end
            end
        end
        @(posedge clk);
        #1;
        for (int m = 0; m < 3; m++) begin
            chk($sformatf("stall%0d", m), sc_of(m), msc[m]);
            chk($sformatf("flush%0d", m), fe_of(m), mfe[m]);
        end
    endtask

    task automatic idle();
        ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0; cnt_clr = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    endtask

    task automatic load_use(input logic [4:0] rd);
        ex_mem_read = 1; ex_rd = rd; id_rs1 = 5; id_use_rs1 = 1;
    endtask

    initial begin
        #1 rst = 1'b0;
        cycle();
        cycle();
        chk("rst_stall", {32'd0, sc0}, 64'd0);
        chk("rst_flush", {32'd0, fe0}, 64'd0);
        rst = 1'b1;
        cycle();

        // Load-use on r5, EX then takes the bubble.
        load_use(5'd5);
        cycle();
        idle();
        repeat (4) cycle();

        // Same dependency through x0.
        load_use(5'd0); id_rs1 = 0;
        cycle();
        idle();
        cycle();

        // Memory wait: four frozen cycles then the ready cycle.
        mem_req = 1; mem_ready = 0;
        repeat (4) cycle();
        mem_ready = 1;
        cycle();
        idle();
        cycle();

        // Branch and hazard together.
        load_use(5'd5); ex_branch_taken = 1;
        cycle();
        idle();
        cycle();

        // Long bubble interrupted by a reset pulse in its second cycle.
        load_use(5'd5);
        cycle();
        idle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (3) cycle();

        // Saturation of the narrow counter, then clear against a stall.
        cnt_clr = 1;
        cycle();
        cnt_clr = 0; mem_req = 1; mem_ready = 0;
        repeat (20) cycle();
        chk("sat4", {60'd0, sc2}, 64'd15);
        cnt_clr = 1;
        cycle();
        chk("clr4", {60'd0, sc2}, 64'd0);
        idle();
        cycle();

        for (int i = 0; i < 400; i++) begin
            id_rs1          = 5'($urandom_range(0, 3));
            id_rs2          = 5'($urandom_range(0, 3));
            ex_rd           = 5'($urandom_range(0, 3));
            id_use_rs1      = 1'($urandom_range(0, 1));
            id_use_rs2      = 1'($urandom_range(0, 1));
            ex_mem_read     = ($urandom_range(0, 99) < 40);
            ex_branch_taken = ($urandom_range(0, 99) < 10);
            mem_req         = ($urandom_range(0, 99) < 30);
            mem_ready       = 1'($urandom_range(0, 1));
            cnt_clr         = ($urandom_range(0, 99) < 3);
            rst             = ($urandom_range(0, 99) >= 2);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
